// File: rtl/pmem_line_responder_pkg.sv
// pmem_pkg: shared constants and the responder state type.
//   LINE_WIDTH   - bits per cacheline
//   OFFSET_BITS  - byte-offset bits of a line address (ignored for indexing)
//   pmem_state_t - responder FSM states
package pmem_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int OFFSET_BITS = 5;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_if.sv
// pmem_line_responder_if: cacheline port between the cache controller and
// physical memory.
//   master - cache side: drives address, read/write requests and write line
//   slave  - memory side: drives the read line and the completion pulse
interface pmem_line_responder_if #(
  parameter int LINE_WIDTH = pmem_pkg::LINE_WIDTH
);

  logic [31:0]           pmem_address;
  logic                  pmem_read;
  logic                  pmem_write;
  logic [LINE_WIDTH-1:0] pmem_wdata;
  logic [LINE_WIDTH-1:0] pmem_rdata;
  logic                  pmem_resp;

  modport master (
    output pmem_address, pmem_read, pmem_write, pmem_wdata,
    input  pmem_rdata, pmem_resp
  );

  modport slave (
    input  pmem_address, pmem_read, pmem_write, pmem_wdata,
    output pmem_rdata, pmem_resp
  );

endinterface

// File: rtl/pmem_line_responder_array.sv
// pmem_line_array: line storage for the responder.
//   clk, rst_n - clock and asynchronous active-low reset (clears valid bits
//                and the read register; line data itself is not reset)
//   we, re     - write commit / read capture strobes
//   idx        - line index
//   wdata      - line to store
//   rdata      - registered read line; lines never written read as zero
module pmem_line_array #(
  parameter int LINE_WIDTH = pmem_pkg::LINE_WIDTH,
  parameter int INDEX_BITS = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [LINE_WIDTH-1:0] wdata,
  output logic [LINE_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << INDEX_BITS;

  logic [LINE_WIDTH-1:0] lines [DEPTH];
  logic [DEPTH-1:0]      valid;

  // Data storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (we) lines[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid <= '0;
    else if (we) valid[idx] <= 1'b1;
  end

  // Valid gating hides whatever garbage the unreset storage holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata <= '0;
    else if (re) rdata <= valid[idx] ? lines[idx] : '0;
  end

endmodule

// File: rtl/pmem_line_responder.sv
// pmem_line_responder: memory-side target of the cache's cacheline port.
// Accepts one line read or write at a time, waits LATENCY cycles from the
// request cycle, then pulses pmem_resp for one cycle.
//   clk, rst_n - clock and asynchronous active-low reset
//   bus        - cacheline port (slave side)
//   prot_err   - sticky protocol-violation flag, cleared only by reset
module pmem_line_responder #(
  parameter int LINE_WIDTH = pmem_pkg::LINE_WIDTH,
  parameter int INDEX_BITS = 6,
  parameter int LATENCY    = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  pmem_line_responder_if.slave bus,
  output logic                 prot_err
);

  import pmem_pkg::*;

  localparam int                CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(LATENCY - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

  pmem_state_t           state;
  logic [CNT_W-1:0]      cnt;
  logic                  rd_q;
  logic                  wr_q;
  logic [INDEX_BITS-1:0] idx_q;
  logic [LINE_WIDTH-1:0] wdata_q;
  logic                  resp_q;

  logic [INDEX_BITS-1:0] req_idx;
  logic                  one_req;
  logic                  both_req;
  logic                  wait_err;
  logic                  enter_resp;
  logic                  commit_is_write;
  logic [INDEX_BITS-1:0] commit_idx;
  logic [LINE_WIDTH-1:0] commit_wdata;
  logic                  unused_addr_bits;

  assign req_idx  = bus.pmem_address[OFFSET_BITS +: INDEX_BITS];
  assign one_req  = bus.pmem_read ^ bus.pmem_write;
  assign both_req = bus.pmem_read & bus.pmem_write;
  assign wait_err = (bus.pmem_read != rd_q) || (bus.pmem_write != wr_q) ||
                    (req_idx != idx_q);

  assign unused_addr_bits = ^{bus.pmem_address[31:OFFSET_BITS+INDEX_BITS],
                              bus.pmem_address[OFFSET_BITS-1:0]};

  // With LATENCY==1 the array access happens on the acceptance edge itself,
  // before the latches hold anything, so it must use the live request.
  always_comb begin
    enter_resp      = 1'b0;
    commit_is_write = wr_q;
    commit_idx      = idx_q;
    commit_wdata    = wdata_q;
    if (state == IDLE) begin
      enter_resp      = one_req && (LATENCY == 1);
      commit_is_write = bus.pmem_write;
      commit_idx      = req_idx;
      commit_wdata    = bus.pmem_wdata;
    end else if (state == WAIT) begin
      enter_resp = (cnt == CNT_ONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      idx_q    <= '0;
      wdata_q  <= '0;
      resp_q   <= 1'b0;
      prot_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          resp_q <= 1'b0;
          if (both_req) begin
            prot_err <= 1'b1;
          end else if (one_req) begin
            rd_q    <= bus.pmem_read;
            wr_q    <= bus.pmem_write;
            idx_q   <= req_idx;
            wdata_q <= bus.pmem_wdata;
            cnt     <= CNT_LOAD;
            if (LATENCY == 1) begin
              state  <= RESP;
              resp_q <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_err) prot_err <= 1'b1;
          if (cnt == CNT_ONE) begin
            state  <= RESP;
            resp_q <= 1'b1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        RESP: begin
          state  <= IDLE;
          resp_q <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          resp_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pmem_resp = resp_q;

  pmem_line_array #(
    .LINE_WIDTH (LINE_WIDTH),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (enter_resp & commit_is_write),
    .re    (enter_resp & ~commit_is_write),
    .idx   (commit_idx),
    .wdata (commit_wdata),
    .rdata (bus.pmem_rdata)
  );

endmodule

// File: tb/tb_pmem_line_responder.sv
// tb_pmem_line_responder: directed bench for pmem_line_responder.
// u_dut4 runs with LATENCY=4, u_dut1 with LATENCY=1 for back-to-back pulses.
module tb_pmem_line_responder;

  localparam int LW      = 256;
  localparam int TIMEOUT = 20;

  logic clk;
  logic rst_n;
  logic prot_err4;
  logic prot_err1;

  int checks   = 0;
  int failures = 0;

  pmem_line_responder_if #(.LINE_WIDTH(LW)) if4 ();
  pmem_line_responder_if #(.LINE_WIDTH(LW)) if1 ();

  pmem_line_responder #(.LINE_WIDTH(LW), .INDEX_BITS(6), .LATENCY(4)) u_dut4 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if4),
    .prot_err (prot_err4)
  );

  pmem_line_responder #(.LINE_WIDTH(LW), .INDEX_BITS(6), .LATENCY(1)) u_dut1 (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (if1),
    .prot_err (prot_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic          is_write;
    logic [31:0]   addr;
    logic [LW-1:0] wdata;
    logic [LW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs [11];

  localparam logic [LW-1:0] D_DB = {8{32'hDEAD_BEEF}};
  localparam logic [LW-1:0] D_A  = {4{64'hA5A5_0000_FFFF_1234}};
  localparam logic [LW-1:0] D_B  = {8{32'hCAFE_F00D}};
  localparam logic [LW-1:0] D_C  = {8{32'h4040_4040}};
  localparam logic [LW-1:0] D_D  = {8{32'h0200_0200}};
  localparam logic [LW-1:0] D_F  = {8{32'h0100_0100}};

  task automatic checkOutput(input string name, input logic [LW-1:0] actual,
                             input logic [LW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic driveReq(input bit sel, input logic rd, input logic wr,
                          input logic [31:0] addr, input logic [LW-1:0] wd);
    if (sel) begin
      if1.pmem_read    = rd;
      if1.pmem_write   = wr;
      if1.pmem_address = addr;
      if1.pmem_wdata   = wd;
    end else begin
      if4.pmem_read    = rd;
      if4.pmem_write   = wr;
      if4.pmem_address = addr;
      if4.pmem_wdata   = wd;
    end
  endtask

  function automatic logic getResp(input bit sel);
    return sel ? if1.pmem_resp : if4.pmem_resp;
  endfunction

  function automatic logic [LW-1:0] getRdata(input bit sel);
    return sel ? if1.pmem_rdata : if4.pmem_rdata;
  endfunction

  function automatic logic getErr(input bit sel);
    return sel ? prot_err1 : prot_err4;
  endfunction

  // Entered just after a rising edge; k counts cycles from the request cycle.
  // Returns at the falling edge of the resp cycle, or after TIMEOUT cycles.
  task automatic waitResp(input bit sel, input int start_k, output int lat);
    int  k;
    bit  seen;
    k    = start_k;
    seen = 1'b0;
    while (!seen && k <= TIMEOUT) begin
      @(negedge clk);
      if (getResp(sel)) begin
        seen = 1'b1;
      end else begin
        k++;
        @(posedge clk);
        #1;
      end
    end
    lat = k;
  endtask

  task automatic applyStimulus(input bit sel, input logic is_write,
                               input logic [31:0] addr, input logic [LW-1:0] wd,
                               input int exp_lat, input logic [LW-1:0] exp_rdata,
                               input logic exp_err, input string tag);
    int lat;
    driveReq(sel, !is_write, is_write, addr, wd);
    waitResp(sel, 0, lat);
    checkOutput({tag, " latency"}, LW'(lat), LW'(exp_lat));
    checkOutput({tag, " rdata"}, getRdata(sel), exp_rdata);
    checkOutput({tag, " prot_err"}, LW'(getErr(sel)), LW'(exp_err));
    @(posedge clk);
    #1;
    driveReq(sel, 1'b0, 1'b0, 32'h0, '0);
  endtask

  task automatic doReset();
    driveReq(1'b0, 1'b0, 1'b0, 32'h0, '0);
    driveReq(1'b1, 1'b0, 1'b0, 32'h0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset resp4", LW'(if4.pmem_resp), '0);
    checkOutput("reset rdata4", if4.pmem_rdata, '0);
    checkOutput("reset prot_err4", LW'(prot_err4), '0);
    checkOutput("reset resp1", LW'(if1.pmem_resp), '0);
    checkOutput("reset prot_err1", LW'(prot_err1), '0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    int resp_count;

    vecs[0]  = '{1'b0, 32'h0000_0040, '0,   '0};
    vecs[1]  = '{1'b1, 32'h0000_0080, D_DB, '0};
    vecs[2]  = '{1'b0, 32'h0000_009C, '0,   D_DB};
    vecs[3]  = '{1'b1, 32'h0000_07C0, D_A,  D_DB};
    vecs[4]  = '{1'b0, 32'h0000_07C0, '0,   D_A};
    vecs[5]  = '{1'b0, 32'h0000_0800, '0,   '0};
    vecs[6]  = '{1'b1, 32'h0000_0080, D_B,  '0};
    vecs[7]  = '{1'b0, 32'h0000_009F, '0,   D_B};
    vecs[8]  = '{1'b1, 32'h0000_0040, D_C,  D_B};
    vecs[9]  = '{1'b0, 32'h0000_0040, '0,   D_C};
    vecs[10] = '{1'b0, 32'h0000_07DF, '0,   D_A};

    doReset();

    // Transaction table on the LATENCY=4 responder.
    for (int i = 0; i < 11; i++) begin
      applyStimulus(1'b0, vecs[i].is_write, vecs[i].addr, vecs[i].wdata, 4,
                    vecs[i].exp_rdata, 1'b0, $sformatf("vec%0d", i));
    end

    // Index change while waiting: data still comes from the original line.
    driveReq(1'b0, 1'b1, 1'b0, 32'h0000_0040, '0);
    @(posedge clk);
    #1;
    driveReq(1'b0, 1'b1, 1'b0, 32'h0000_0060, '0);
    waitResp(1'b0, 1, lat);
    checkOutput("idxchg latency", LW'(lat), LW'(4));
    checkOutput("idxchg rdata", if4.pmem_rdata, D_C);
    checkOutput("idxchg prot_err", LW'(prot_err4), LW'(1));
    @(posedge clk);
    #1;
    driveReq(1'b0, 1'b0, 1'b0, 32'h0, '0);

    // Simultaneous read and write in IDLE.
    doReset();
    driveReq(1'b0, 1'b1, 1'b1, 32'h0000_0040, D_D);
    resp_count = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if4.pmem_resp) resp_count++;
      @(posedge clk);
      #1;
    end
    checkOutput("rw resp count", LW'(resp_count), '0);
    checkOutput("rw prot_err", LW'(prot_err4), LW'(1));
    driveReq(1'b0, 1'b0, 1'b0, 32'h0, '0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rw prot_err sticky", LW'(prot_err4), LW'(1));
    applyStimulus(1'b0, 1'b0, 32'h0000_0040, '0, 4, '0, 1'b1, "rw after");

    // Reset during the wait of a write aborts it.
    doReset();
    driveReq(1'b0, 1'b0, 1'b1, 32'h0000_0200, D_D);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst resp", LW'(if4.pmem_resp), '0);
    driveReq(1'b0, 1'b0, 1'b0, 32'h0, '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    resp_count = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (if4.pmem_resp) resp_count++;
      @(posedge clk);
      #1;
    end
    checkOutput("midrst stray resp", LW'(resp_count), '0);
    applyStimulus(1'b0, 1'b0, 32'h0000_0200, '0, 4, '0, 1'b0, "midrst read");

    // Back-to-back write then read on the LATENCY=1 responder.
    applyStimulus(1'b1, 1'b1, 32'h0000_0100, D_F, 1, '0, 1'b0, "b2b write");
    applyStimulus(1'b1, 1'b0, 32'h0000_0100, '0, 1, D_F, 1'b0, "b2b read");
    @(negedge clk);
    checkOutput("b2b resp drop", LW'(if1.pmem_resp), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pmem_line_responder.md
# pmem_line_responder

Physical-memory responder for the cache's cacheline port: the target side of the `pmem_read`/`pmem_write`/`pmem_address`/`pmem_resp` handshake driven by the cache controller. It accepts one 256-bit line read or write at a time, holds it for a parameterised latency, then pulses `pmem_resp` for exactly one cycle. Storage is an internal line array. It is the memory endpoint for cache-level simulation and for FPGA bring-up without DRAM.

## Interface
- `LINE_WIDTH`, 256: bits per cacheline.
- `INDEX_BITS`, 6: line-array index width; depth is 2^INDEX_BITS lines.
- `LATENCY`, 4: request cycle to `pmem_resp` cycle; legal range ≥1.

Ports:
- `clk`  in  1  single clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pmem_address`  in  32  line address; bits [4:0] are ignored and index = [5+INDEX_BITS-1:5].
- `pmem_read`  in  1  read request, level-held by the initiator until `pmem_resp`.
- `pmem_write`  in  1  write request, level-held until `pmem_resp`.
- `pmem_wdata`  in  LINE_WIDTH  write line, sampled at acceptance.
- `pmem_rdata`  out  LINE_WIDTH  read line, valid during the `pmem_resp` cycle of a read.
- `pmem_resp`  out  1  one-cycle completion pulse.
- `prot_err`  out  1  sticky protocol-violation flag.

## Operation
- State machine states: IDLE, WAIT, RESP.
- **IDLE**
  - When exactly one of `pmem_read`/`pmem_write` is high, latch the op, the index and `pmem_wdata`, and load the counter with LATENCY-1.
  - Go to RESP if LATENCY==1; otherwise go to WAIT.
- **WAIT**
  - Decrement the counter. At 1, go to RESP.
  - Request inputs are ignored; the latched values are used.
- **RESP**
  - `pmem_resp`=1. Go unconditionally to IDLE.
- **Write commit:** on the edge entering RESP, `array[idx] <= wdata` and `valid[idx] <= 1`.
- **Read data:** on the edge entering RESP, `pmem_rdata <= valid[idx] ? array[idx] : '0`. The value holds until the next read's RESP entry. Writes leave `pmem_rdata` unchanged.
- **Never-written lines** read as all-zero.
- **Back-to-back requests:** RESP is followed by IDLE. The initiator drops or changes its request on the edge ending RESP, so a new request present in the cycle after RESP is accepted normally. A write-back followed by an allocate therefore costs LATENCY+LATENCY+1 cycles end to end.
- **prot_err** is set, and only cleared by reset, on any of:
  - `pmem_read && pmem_write` in IDLE. Nothing is accepted and the FSM stays in IDLE.
  - In WAIT: the request op deasserts, the op changes, or the index changes.
- **Same-line read after write:** a read of a just-written line returns the new data.

## Timing
- Reset values: state=IDLE, `pmem_resp`=0, `pmem_rdata`=0, `prot_err`=0, all valid bits=0. The array data is not reset.
- Reset asserted mid-transaction aborts it: no commit, no `pmem_resp`.
- Request first high in cycle t while in IDLE gives `pmem_resp`=1 in cycle t+LATENCY only.
- `pmem_resp` is registered (a state decode of RESP). There is no combinational path from the inputs to any output.
- Counter width is $clog2(LATENCY+1). There is no wrap-around; the counter reloads only in IDLE.

## Structure
- Package `pmem_pkg`: `LINE_WIDTH`, `OFFSET_BITS`=5, and the state enum `pmem_state_t` {IDLE, WAIT, RESP}.
- Sub-module `pmem_line_array`:
  - Synchronous-write, registered-read line storage.
  - Per-line valid bits with asynchronous clear.
- Top level contains the FSM, the counter, the latches and the error logic.

## Test plan
- **Post-reset read:** reset, then read 0x0000_0040 → `pmem_resp` exactly in cycle t+4, `pmem_rdata`=0, `prot_err`=0.
- **Write then read:** write 0x0000_0080 with data {8{32'hDEAD_BEEF}}, then read 0x0000_009C → the read returns {8{32'hDEAD_BEEF}} because the offset is ignored.
- **Back-to-back with LATENCY=1:** write 0x100 immediately followed by read 0x100 in the cycle after RESP → two single-cycle resp pulses, 1 idle cycle apart, and the read returns the new data.
- **Simultaneous read and write:** `pmem_read` and `pmem_write` both high in IDLE → no `pmem_resp`, `prot_err`=1 and it stays 1.
- **Index change in WAIT:** change `pmem_address` from 0x40 to 0x60 during WAIT → resp still at t+4, data from 0x40, `prot_err`=1.
- **Reset mid-write:** assert `rst_n` low during the WAIT of a write to 0x200, then read 0x200 → 0 returned and no stray `pmem_resp` pulse.
